// File: rtl/cswap_pkg.sv
// rtl/cswap_pkg.sv - shared constants, triple type and popcount helper for the cswap stage
package cswap_pkg;

  localparam int unsigned W_DEFAULT     = 8;
  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned W_MAX         = 32;
  localparam int unsigned POP_W         = 6;

  // Words are carried at the widest supported width; the stage uses the low W bits.
  typedef struct packed {
    logic             ctrl;
    logic [W_MAX-1:0] a;
    logic [W_MAX-1:0] b;
  } triple_t;

  function automatic logic [POP_W-1:0] popcount(input logic [W_MAX-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < W_MAX; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/cswap_word.sv
// rtl/cswap_word.sv - combinational W-bit controlled swap (Fredkin gate on words)
module cswap_word import cswap_pkg::*; #(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         in_ctrl,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_ctrl,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b
);

  assign out_ctrl = in_ctrl;
  assign out_a    = in_ctrl ? in_b : in_a;
  assign out_b    = in_ctrl ? in_a : in_b;

endmodule

// File: rtl/cswap_stream_stage.sv
// rtl/cswap_stream_stage.sv - registered controlled-swap stage with skid buffer, counters and checker
module cswap_stream_stage import cswap_pkg::*; #(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_ctrl,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ctrl,
  output logic [W-1:0]     out_a,
  output logic [W-1:0]     out_b,
  input  logic             fault_inj,
  output logic [CNT_W-1:0] swap_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  localparam int unsigned SUM_W = $clog2(2 * W + 1);

  logic             word_ctrl;
  logic [W-1:0]     word_a;
  logic [W-1:0]     word_b;
  logic [W-1:0]     calc_a;
  logic [SUM_W-1:0] pop_in;
  logic [SUM_W-1:0] pop_out;
  logic             accept;
  logic             drain;
  triple_t          new_t;

  triple_t          out_q, out_d;
  triple_t          skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             init_q, init_d;
  logic [CNT_W-1:0] swap_cnt_q, swap_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_sticky_q, err_sticky_d;
  logic             unused_hi_bits;

  cswap_word #(.W(W)) u_word (
    .in_ctrl  (in_ctrl),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_ctrl (word_ctrl),
    .out_a    (word_a),
    .out_b    (word_b)
  );

  // The fault hook corrupts one bit so the conservation check has something to catch.
  assign calc_a  = word_a ^ W'(fault_inj);
  assign pop_in  = SUM_W'(popcount(W_MAX'(in_a))) + SUM_W'(popcount(W_MAX'(in_b)));
  assign pop_out = SUM_W'(popcount(W_MAX'(calc_a))) + SUM_W'(popcount(W_MAX'(word_b)));
  assign new_t   = '{ctrl: word_ctrl, a: W_MAX'(calc_a), b: W_MAX'(word_b)};

  // in_ready comes from flops only; init_q keeps it low until the first edge after reset.
  assign in_ready = init_q & ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = out_valid_q & out_ready;

  // Next-state for the two-entry buffer and the counters.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    init_d       = 1'b1;
    swap_cnt_d   = swap_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;

    if (skid_valid_q) begin
      // Full: no accept possible; refill the output register from skid when it drains.
      if (drain) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || drain) begin
      out_valid_d = accept;
      if (accept) begin
        out_d = new_t;
      end
    end else if (accept) begin
      skid_d       = new_t;
      skid_valid_d = 1'b1;
    end

    if (accept && in_ctrl) begin
      swap_cnt_d = swap_cnt_q + CNT_W'(1);
    end
    if (accept && (pop_in != pop_out)) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      init_q       <= 1'b0;
      swap_cnt_q   <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      init_q       <= init_d;
      swap_cnt_q   <= swap_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ctrl   = out_q.ctrl;
  assign out_a      = out_q.a[W-1:0];
  assign out_b      = out_q.b[W-1:0];
  assign swap_cnt   = swap_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;

  // Bits above W are always zero and never leave the stage.
  assign unused_hi_bits = ^{out_q.a, out_q.b};

endmodule

// File: tb/tb_cswap_stream_stage.sv
// tb/tb_cswap_stream_stage.sv - self-checking bench for cswap_stream_stage
module tb_cswap_stream_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // W=8, CNT_W=16 stage and a CNT_W=4 copy sharing its inputs
  logic        in_valid = 0, in_ctrl = 0, fault_inj = 0, out_ready = 0;
  logic [7:0]  in_a = 0, in_b = 0;
  logic        in_ready, out_valid, out_ctrl, err_sticky;
  logic [7:0]  out_a, out_b;
  logic [15:0] swap_cnt, err_cnt;
  logic        in_ready4, out_valid4, out_ctrl4, err_sticky4;
  logic [7:0]  out_a4, out_b4;
  logic [3:0]  swap_cnt4, err_cnt4;

  // W=1 stage
  logic        in_valid1 = 0, in_ctrl1 = 0, fault1 = 0, out_ready1 = 0;
  logic [0:0]  in_a1 = 0, in_b1 = 0;
  logic        in_ready1, out_valid1, out_ctrl1, err_sticky1;
  logic [0:0]  out_a1, out_b1;
  logic [15:0] swap_cnt1, err_cnt1;

  logic unused_tb;
  assign unused_tb = ^{in_ready4, out_valid4, out_ctrl4, err_sticky4, out_a4, out_b4, err_sticky1, err_cnt1};

  cswap_stream_stage #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_a(out_a), .out_b(out_b), .fault_inj(fault_inj), .swap_cnt(swap_cnt), .err_cnt(err_cnt),
    .err_sticky(err_sticky)
  );

  cswap_stream_stage #(.W(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_ctrl(in_ctrl),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid4), .out_ready(out_ready), .out_ctrl(out_ctrl4),
    .out_a(out_a4), .out_b(out_b4), .fault_inj(fault_inj), .swap_cnt(swap_cnt4), .err_cnt(err_cnt4),
    .err_sticky(err_sticky4)
  );

  cswap_stream_stage #(.W(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .in_ctrl(in_ctrl1),
    .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1), .out_ctrl(out_ctrl1),
    .out_a(out_a1), .out_b(out_b1), .fault_inj(fault1), .swap_cnt(swap_cnt1), .err_cnt(err_cnt1),
    .err_sticky(err_sticky1)
  );

  typedef struct packed { logic c; logic a; logic b; logic ea; logic eb; } vec1_t;
  typedef struct packed { logic c; logic [7:0] a; logic [7:0] b; } trip_t;
  typedef struct { logic c; logic [7:0] a; logic [7:0] b; int acc; } exp_t;

  vec1_t v1 [8];
  trip_t t2 [3];
  exp_t  exp_q [$];
  int    mdl_swap = 0;
  int    mdl_err = 0;
  bit    check_lat = 0;
  bit    stall_seen = 0;
  logic [16:0] hold_val = '0;
  int    last_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: swap when ctrl is set, then flip bit 0 of A under fault injection.
  function automatic exp_t model(input logic c, input logic [7:0] a, input logic [7:0] b, input logic f);
    exp_t r;
    r.c   = c;
    r.a   = c ? b : a;
    r.b   = c ? a : b;
    if (f) r.a[0] = ~r.a[0];
    r.acc = 0;
    return r;
  endfunction

  // Scoreboard for the W=8 stage: check transfers, stability under stall, then record accepts.
  always @(negedge clk) begin
    exp_t e, m;
    if (!rst_n) begin
      stall_seen = 0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({out_ctrl, out_a, out_b}), 32'(hold_val));
      end
      stall_seen = out_valid && !out_ready;
      hold_val   = {out_ctrl, out_a, out_b};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_triple", 32'({out_ctrl, out_a, out_b}), 32'({e.c, e.a, e.b}));
          if (check_lat) chk("latency", 32'(cyc), 32'(e.acc));
        end
      end
      if (in_valid && in_ready) begin
        m = model(in_ctrl, in_a, in_b, fault_inj);
        m.acc = cyc + 1;
        exp_q.push_back(m);
        if (in_ctrl) mdl_swap++;
        if (($countones(in_a) + $countones(in_b)) != ($countones(m.a) + $countones(m.b)) && mdl_err < 65535)
          mdl_err++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'({out_ctrl, out_a, out_b}), 32'd0);
    chk("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_err_sticky", 32'(err_sticky), 32'd0);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    exp_q.delete();
    mdl_swap = 0;
    mdl_err  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(in_ready), 32'd1);
    chk("no_stale_after_reset", 32'(out_valid), 32'd0);
  endtask

  // Present a triple until it is accepted; returns at 1 time unit after the accepting edge.
  task automatic send(input logic c, input logic [7:0] a, input logic [7:0] b, input logic f);
    bit acc;
    int n;
    in_valid = 1; in_ctrl = c; in_a = a; in_b = b; fault_inj = f;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 32'(n), 32'd0);
    last_wait = n;
    in_valid = 0; fault_inj = 0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit done;
    int bad_thru;
    // c, a, b, expected a', expected b'
    v1[0] = 5'b000_00; v1[1] = 5'b001_01; v1[2] = 5'b010_10; v1[3] = 5'b011_11;
    v1[4] = 5'b100_00; v1[5] = 5'b101_10; v1[6] = 5'b110_01; v1[7] = 5'b111_11;
    t2[0] = {1'b1, 8'hA5, 8'h3C};
    t2[1] = {1'b0, 8'h11, 8'h22};
    t2[2] = {1'b1, 8'hFF, 8'h00};

    do_reset();

    // W=1 truth table, one result per accept, exactly one cycle later
    out_ready1 = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("w1_idle", 32'(out_valid1), 32'd0);
      chk("w1_ready", 32'(in_ready1), 32'd1);
      in_valid1 = 1; in_ctrl1 = v1[i].c; in_a1 = v1[i].a; in_b1 = v1[i].b;
      @(posedge clk); #1;
      in_valid1 = 0;
      chk("w1_valid", 32'(out_valid1), 32'd1);
      chk("w1_out", 32'({out_ctrl1, out_a1, out_b1}), 32'({v1[i].c, v1[i].ea, v1[i].eb}));
    end
    @(posedge clk); #1;
    chk("w1_swap_cnt", 32'(swap_cnt1), 32'd4);

    // Back-pressure: two fill the buffer, third waits
    out_ready = 0;
    check_lat = 0;
    send(t2[0].c, t2[0].a, t2[0].b, 0);
    send(t2[1].c, t2[1].a, t2[1].b, 0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    fork
      send(t2[2].c, t2[2].a, t2[2].b, 0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("bp_hold", 32'({out_valid, out_ctrl, out_a, out_b}), 32'({1'b1, 1'b1, 8'h3C, 8'hA5}));
          chk("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
      end
    join
    drain_wait();
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Continuous streaming at full rate
    check_lat = 1;
    bad_thru = 0;
    for (int i = 0; i < 100; i++) begin
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
      if (last_wait != 1) bad_thru++;
    end
    chk("stream_throughput", 32'(bad_thru), 32'd0);
    drain_wait();
    chk("stream_err_cnt", 32'(err_cnt), 32'd0);
    chk("stream_swap_cnt", 32'(swap_cnt), 32'(mdl_swap & 'hFFFF));

    // Random gaps and random back-pressure
    check_lat = 0;
    done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    drain_wait();
    chk("rand_swap_cnt", 32'(swap_cnt), 32'(mdl_swap & 'hFFFF));

    // Fault injection trips the checker; a clean triple afterwards leaves it latched
    check_lat = 1;
    send(0, 8'h00, 8'h00, 1);
    chk("fault_out", 32'({out_valid, out_a}), 32'({1'b1, 8'h01}));
    chk("fault_err_cnt", 32'(err_cnt), 32'd1);
    chk("fault_sticky", 32'(err_sticky), 32'd1);
    send(1, 8'h5A, 8'h0F, 0);
    @(posedge clk); #1;
    chk("clean_err_cnt", 32'(err_cnt), 32'd1);
    chk("clean_sticky", 32'(err_sticky), 32'd1);
    drain_wait();

    // Asynchronous reset with both entries occupied
    out_ready = 0;
    send(1, 8'hC3, 8'h18, 0);
    send(0, 8'h77, 8'h88, 0);
    chk("pre_rst_full", 32'({out_valid, in_ready}), 32'({1'b1, 1'b0}));
    do_reset();
    out_ready = 1;
    check_lat = 1;
    send(1, 8'h12, 8'h34, 0);
    chk("post_rst_first", 32'({out_valid, out_ctrl, out_a, out_b}), 32'({1'b1, 1'b1, 8'h34, 8'h12}));
    drain_wait();

    // Counter wrap and saturation on the CNT_W=4 copy
    do_reset();
    for (int i = 0; i < 17; i++) send(1, 8'($urandom), 8'($urandom), 0);
    drain_wait();
    chk("wrap_swap_cnt4", 32'(swap_cnt4), 32'd1);
    chk("wrap_swap_cnt", 32'(swap_cnt), 32'(mdl_swap & 'hFFFF));
    for (int i = 0; i < 17; i++) send(0, 8'($urandom), 8'($urandom), 1);
    drain_wait();
    chk("sat_err_cnt4", 32'(err_cnt4), 32'd15);
    chk("sat_err_cnt", 32'(err_cnt), 32'(mdl_err));
    chk("sat_swap_cnt4", 32'(swap_cnt4), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
